dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port data memory. It shares the memory between the CPU load/store port (port 0) and a debug/DMA port (port 1) with round-robin fairness. Each access runs through a fixed three-phase sequence: grant, memory access, registered response. Alignment and funct3 legality are checked before any write reaches the memory.

## Interface
- ADDR_WIDTH, 32, address width of both ports and the memory side
- DATA_WIDTH, 32, data width; the block supports only 32

- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- p0_req / p1_req  in  1  access request; held stable with the other request fields until the matching ack
- p0_we / p1_we  in  1  1 = store, 0 = load
- p0_funct3 / p1_funct3  in  3  RISC-V load/store funct3
- p0_addr / p1_addr  in  ADDR_WIDTH  byte address
- p0_wdata / p1_wdata  in  DATA_WIDTH  store data, right-aligned
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_err / p1_err  out  1  valid only with ack; 1 = access rejected
- p0_rdata / p1_rdata  out  DATA_WIDTH  registered load result; valid with ack and held until the next ack on that port
- mem_wr_en  out  1  memory write enable
- mem_funct3  out  3  funct3 passed to the memory
- mem_addr  out  ADDR_WIDTH  address passed to the memory
- mem_wr_data  out  DATA_WIDTH  store data passed to the memory
- mem_rd_data  in  DATA_WIDTH  combinational read data from the memory
- busy  out  1  1 whenever state is not IDLE
- grant_id  out  1  port that owns the current transaction

## Operation
- FSM states: IDLE, ACC, RESP.
  - IDLE → ACC when any request is sampled.
  - ACC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Latching: at the IDLE→ACC edge, the winning port's we/funct3/addr/wdata are captured into internal registers, and grant_id is updated.
- Arbitration:
  - Only one request pending: that port wins.
  - Both pending: the port not granted last time wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- Legality check on the latched request:
  - Loads accept funct3 000, 001, 010, 100, 101. Stores accept 000, 001, 010. Anything else is illegal.
  - Half-word accesses require addr[0]=0. Word accesses require addr[1:0]=00.
- ACC phase:
  - mem_funct3, mem_addr and mem_wr_data are driven from the latched registers.
  - mem_wr_en = latched_we & legal & ~reset; the write commits at the end of ACC.
  - For a legal load, mem_rd_data is captured into the owner's rdata register at the end of ACC.
- Illegal access: no write, rdata is loaded with 0, and err=1 at ack.
- RESP phase: the owner's ack=1 for exactly one cycle; the other port's ack stays 0.
- Outside ACC, mem_wr_en, mem_funct3, mem_addr and mem_wr_data are all 0.
- A request that is still high in the cycle after its ack counts as a new request.
- The arbiter does no sign or zero extension; it passes memory data through unmodified.

## Timing
- Request sampled at edge N:
  - ACC occupies cycle N+1.
  - ack is high in cycle N+2.
  - Earliest re-grant is sampled at edge N+3.
- Sustained throughput: one access per 3 cycles. Under continuous contention the two ports alternate strictly.
- Reset values:
  - state = IDLE, last_grant = 1, grant_id = 0
  - all acks and errs = 0, both rdata registers = 0
  - all mem_* outputs = 0, busy = 0
- Reset asserted during ACC: mem_wr_en is forced to 0 that cycle, so no memory write happens. State returns to IDLE and no ack is issued.
- Reset asserted during RESP: the ack is suppressed at the next edge, and all registers take their reset values.
- Requests arriving while busy are not sampled until the FSM is back in IDLE; requesters hold them.

## Test plan
- p0 sw, addr 0x8, wdata 0xDEADBEEF, then p0 lw 0x8 → mem_wr_en high only in the ACC cycle of the first access; second ack arrives 2 cycles after sampling with rdata 0xDEADBEEF and err 0.
- p0 and p1 both request lw continuously from reset → grants go 0,1,0,1; acks are spaced 3 cycles apart; grant_id alternates.
- p1 sh at addr 0x3 → no memory write (mem_wr_en stays 0); p1_ack=1 with p1_err=1 and p1_rdata=0; memory contents unchanged.
- p0 load with funct3 011 → err=1 with rdata 0; the next legal p0 lw succeeds with err=0.
- p0 sw 0x10 with reset asserted in the ACC cycle → mem_wr_en stays 0 and no ack is issued; after reset, lw 0x10 returns the old contents.
- p1 lb at addr 0x5 → mem_funct3 000 and mem_addr 0x5 during ACC; p1_rdata equals mem_rd_data sampled at the end of ACC.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter sequencing grant, access and registered response to a single-port data memory.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [2:0]            p0_funct3,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic                  p0_err,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [2:0]            p1_funct3,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_err,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  grant_id
);
    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
    state_t                state;
    logic                  last_grant, we_q, win, legal, f3_ok, align_ok, in_acc, load_rd;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rd_next;
    always_comb begin
        win      = (p0_req & p1_req) ? ~last_grant : p1_req;
        f3_ok    = we_q ? (f3_q <= 3'd2) : (f3_q <= 3'd2 || f3_q == 3'd4 || f3_q == 3'd5);
        align_ok = (f3_q[1:0] == 2'b01) ? ~addr_q[0] :
                   (f3_q[1:0] == 2'b10) ? (addr_q[1:0] == 2'b00) : 1'b1;
        legal    = f3_ok & align_ok;
        in_acc   = state == ACC;
        load_rd  = ~legal | ~we_q;
        rd_next  = legal ? mem_rd_data : '0;
    end
    // Write enable must drop in the same cycle reset rises, so it is gated combinationally.
    assign mem_wr_en   = in_acc & we_q & legal & ~reset;
    assign mem_funct3  = in_acc ? f3_q : 3'b000;
    assign mem_addr    = in_acc ? addr_q : '0;
    assign mem_wr_data = in_acc ? wdata_q : '0;
    assign busy        = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: if (p0_req | p1_req) begin
                    state      <= ACC;
                    grant_id   <= win;
                    last_grant <= win;
                    we_q       <= win ? p1_we : p0_we;
                    f3_q       <= win ? p1_funct3 : p0_funct3;
                    addr_q     <= win ? p1_addr : p0_addr;
                    wdata_q    <= win ? p1_wdata : p0_wdata;
                end
                ACC: begin
                    state <= RESP;
                    if (grant_id) begin
                        p1_ack <= 1'b1;
                        p1_err <= ~legal;
                        if (load_rd) p1_rdata <= rd_next;
                    end else begin
                        p0_ack <= 1'b1;
                        p0_err <= ~legal;
                        if (load_rd) p0_rdata <= rd_next;
                    end
                end
                default: begin
                    state  <= IDLE;
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    p0_err <= 1'b0;
                    p1_err <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [2:0]  p0_funct3 = 0, p1_funct3 = 0;
    logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
    logic        p0_ack, p0_err, p1_ack, p1_err, mem_wr_en, busy, grant_id;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wr_data, mem_rd_data;
    logic [2:0]  mem_funct3;
    logic [31:0] mem [0:15];
    int          n_tests = 0, n_fail = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    assign mem_rd_data = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            p0_req = rq; p0_we = we; p0_funct3 = f3; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_req = rq; p1_we = we; p1_funct3 = f3; p1_addr = a; p1_wdata = wd;
        end
    endtask

    // One isolated access from IDLE: sample edge, ACC cycle, RESP cycle, back to IDLE.
    task automatic do_acc(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
        drive(p, 1'b1, we, f3, a, wd);
        @(posedge clk); #1;
        check("acc_busy", busy, 1);
        check("acc_grant", grant_id, p);
        check("acc_wen", mem_wr_en, we & ~exp_err);
        check("acc_addr", mem_addr, a);
        check("acc_f3", mem_funct3, f3);
        check("acc_wdata", mem_wr_data, wd);
        check("acc_no_ack", p0_ack | p1_ack, 0);
        @(posedge clk); #1;
        check("resp_ack", p ? p1_ack : p0_ack, 1);
        check("resp_other_ack", p ? p0_ack : p1_ack, 0);
        check("resp_err", p ? p1_err : p0_err, exp_err);
        check("resp_rdata", p ? p1_rdata : p0_rdata, exp_rd);
        check("resp_wen", mem_wr_en, 0);
        check("resp_addr", mem_addr, 0);
        drive(p, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("idle_ack", p0_ack | p1_ack, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'hA0A0A0A0;
        mem[1] = 32'h11223344;
        mem[4] = 32'h55AA55AA;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_acks", {p0_ack, p1_ack, p0_err, p1_err}, 0);
        check("rst_rdata0", p0_rdata, 0);
        check("rst_rdata1", p1_rdata, 0);
        check("rst_mem", {mem_wr_en, mem_funct3}, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mwdata", mem_wr_data, 0);
        // Continuous contention straight out of reset: grants alternate 0,1,0,1.
        drive(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rr_grant", grant_id, k % 2);
            check("rr_busy", busy, 1);
            @(posedge clk); #1;
            check("rr_ack0", p0_ack, (k % 2) == 0);
            check("rr_ack1", p1_ack, (k % 2) == 1);
            check("rr_rdata", (k % 2) ? p1_rdata : p0_rdata, (k % 2) ? 32'h11223344 : 32'hA0A0A0A0);
            @(posedge clk); #1;
            check("rr_idle", busy | p0_ack | p1_ack, 0);
        end
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("rr_quiet", busy, 0);
        // sw then lw to the same word
        do_acc(0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0, 32'hA0A0A0A0);
        check("sw_mem", mem[2], 32'hDEADBEEF);
        do_acc(0, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF);
        // misaligned sh is rejected without touching memory
        do_acc(1, 1'b1, 3'b001, 32'h3, 32'h0000CAFE, 1'b1, 32'h0);
        check("sh_mem0", mem[0], 32'hA0A0A0A0);
        // illegal load funct3, then a legal load recovers
        do_acc(0, 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0);
        do_acc(0, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF);
        // illegal store funct3 and word misalignment
        do_acc(0, 1'b1, 3'b100, 32'h0, 32'h12345678, 1'b1, 32'h0);
        do_acc(1, 1'b0, 3'b010, 32'h6, 32'h0, 1'b1, 32'h0);
        check("ill_mem0", mem[0], 32'hA0A0A0A0);
        // lb passes raw memory data through
        do_acc(1, 1'b0, 3'b000, 32'h5, 32'h0, 1'b0, 32'h11223344);
        // lhu at an even half-word address is legal
        do_acc(0, 1'b0, 3'b101, 32'h6, 32'h0, 1'b0, 32'h11223344);
        // reset during ACC kills the write and the ack
        drive(0, 1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFF0000);
        @(posedge clk); #1;
        check("rst_acc_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_acc_wen", mem_wr_en, 0);
        @(posedge clk); #1;
        check("rst_acc_ack", p0_ack, 0);
        check("rst_acc_idle", busy, 0);
        check("rst_acc_mem", mem[4], 32'h55AA55AA);
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        do_acc(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h55AA55AA);
        // reset during RESP suppresses the following state and clears rdata
        drive(1, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_resp_ack", p1_ack, 1);
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("rst_resp_clr", {p1_ack, p1_err, busy}, 0);
        check("rst_resp_rdata", p1_rdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
